// File: rtl/parallel_to_serial_transmitter.sv
// parallel_to_serial_transmitter: sends one parallel word per frame on a single
// idle-high line as start bit, data LSB first, optional parity bit, stop bit.
//
// Build option: define PARITY_EN to insert an even-parity bit after the data.
//
// Ports:
//   clk        in   1      clock, rising edge
//   clear_n    in   1      asynchronous active-low reset
//   enable     in   1      1 = run, 0 = freeze all state and outputs
//   in         in   WIDTH  parallel word, sampled on the load handshake
//   load_valid in   1      upstream offers a word
//   load_ready out  1      idle, enabled and out of reset
//   serial_out out  1      serial line, idle high
//   busy       out  1      frame in progress
//   done       out  1      pulse on the last cycle of the stop bit
module parallel_to_serial_transmitter #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CW-1:0]    cyc;
    logic [BW-1:0]    bitc;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_nxt;
    logic             done_r;
    logic             cyc_last;
    logic             cyc_pen;
    logic             bit_last;
`ifdef PARITY_EN
    logic             parity_bit;
`endif

    assign shift_nxt = shift >> 1;
    assign cyc_last  = (cyc == CW'(BIT_CYCLES - 1));
    // Second-to-last cycle of a bit; never matches when BIT_CYCLES is 1.
    assign cyc_pen   = (BIT_CYCLES > 1) && (cyc == CW'(BIT_CYCLES - 2));
    assign bit_last  = (bitc == BW'(WIDTH - 1));

    assign load_ready = clear_n && enable && (state == IDLE);
    // A frozen transmitter must not report completion.
    assign done       = done_r && enable;

    // Outputs are registered for the state being entered, so each takes
    // effect on the same edge as the state change.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state      <= IDLE;
            cyc        <= '0;
            bitc       <= '0;
            shift      <= '0;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            done_r     <= 1'b0;
`ifdef PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (enable) begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_valid) begin
                        shift      <= in;
`ifdef PARITY_EN
                        parity_bit <= ^in;
`endif
                        state      <= START;
                        cyc        <= '0;
                        bitc       <= '0;
                        serial_out <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (cyc_last) begin
                        state      <= DATA;
                        cyc        <= '0;
                        bitc       <= '0;
                        serial_out <= shift[0];
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                DATA: begin
                    if (cyc_last) begin
                        cyc   <= '0;
                        shift <= shift_nxt;
                        if (bit_last) begin
                            bitc <= '0;
`ifdef PARITY_EN
                            state      <= PARITY;
                            serial_out <= parity_bit;
`else
                            state      <= STOP;
                            serial_out <= 1'b1;
                            done_r     <= (BIT_CYCLES == 1);
`endif
                        end else begin
                            bitc       <= bitc + 1'b1;
                            serial_out <= shift_nxt[0];
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                PARITY: begin
                    if (cyc_last) begin
                        state      <= STOP;
                        cyc        <= '0;
                        serial_out <= 1'b1;
                        done_r     <= (BIT_CYCLES == 1);
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                STOP: begin
                    if (cyc_last) begin
                        state      <= IDLE;
                        cyc        <= '0;
                        serial_out <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        cyc    <= cyc + 1'b1;
                        done_r <= cyc_pen;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cyc        <= '0;
                    bitc       <= '0;
                    serial_out <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
